// File: rtl/board_mem.sv
// Playfield storage for a 10 x 20 falling-block game, with a line-clear engine.
// Two combinational read ports (game logic and display) see the same storage.
// The clear engine scans from the bottom row upward. Each full row it finds is
// removed by shifting every row above it down by one. The engine then rescans
// the same row position, because a new row has just dropped into it.
module board_mem (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       board_we,
  input  logic [3:0] board_wx,
  input  logic [4:0] board_wy,
  input  logic       board_wdata,
  input  logic [3:0] board_rx,
  input  logic [4:0] board_ry,
  output logic       board_rdata,
  input  logic [3:0] vga_x,
  input  logic [4:0] vga_y,
  output logic       vga_cell,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic       clear_done,
  output logic [4:0] lines_cleared
);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [9:0] rows [20];
  logic [4:0] scan_row;
  logic [4:0] dst;
  logic [4:0] count;
  logic [9:0] rd_row;
  logic [9:0] vga_row;
  logic [9:0] scan_bits;
  logic       scan_full;

  // Row selection for both read ports and the scanner; out-of-range rows read as zero
  always_comb begin
    rd_row    = '0;
    vga_row   = '0;
    scan_bits = '0;
    for (int r = 0; r < 20; r++) begin
      if (board_ry == 5'(r)) rd_row = rows[r];
      if (vga_y == 5'(r)) vga_row = rows[r];
      if (scan_row == 5'(r)) scan_bits = rows[r];
    end
    scan_full = (scan_bits == 10'h3FF);
  end

  // Column selection; an out-of-range column never matches, so it reads as zero
  always_comb begin
    board_rdata = 1'b0;
    vga_cell    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (board_rx == 4'(c)) board_rdata = rd_row[c];
      if (vga_x == 4'(c)) vga_cell = vga_row[c];
    end
  end

  // Cell storage: shifting rows down during a clear, otherwise single-cell writes when idle
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (int r = 0; r < 20; r++) rows[r] <= '0;
    end else if (state == SHIFT) begin
      if (dst == 5'd0) rows[0] <= '0;
      for (int r = 1; r < 20; r++) begin
        if (dst == 5'(r)) rows[r] <= rows[r-1];
      end
    end else if (board_we && !clear_busy) begin
      for (int r = 0; r < 20; r++) begin
        for (int c = 0; c < 10; c++) begin
          if (board_wy == 5'(r) && board_wx == 4'(c)) rows[r][c] <= board_wdata;
        end
      end
    end
  end

  // Engine state register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Engine next-state and status outputs
  always_comb begin
    state_next = state;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) state_next = SCAN;
      end
      SCAN: begin
        clear_busy = 1'b1;
        if (scan_full)               state_next = SHIFT;
        else if (scan_row == 5'd0)   state_next = DONE;
      end
      SHIFT: begin
        clear_busy = 1'b1;
        if (dst == 5'd0) state_next = SCAN;
      end
      DONE: begin
        clear_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Engine bookkeeping: scan position, shift destination, running and reported line counts
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      scan_row      <= '0;
      dst           <= '0;
      count         <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            scan_row <= 5'd19;
            count    <= '0;
          end
        end
        SCAN: begin
          if (scan_full)              dst      <= scan_row;
          else if (scan_row != 5'd0)  scan_row <= scan_row - 5'd1;
        end
        SHIFT: begin
          if (dst != 5'd0) dst   <= dst - 5'd1;
          else             count <= count + 5'd1;
        end
        DONE: begin
          lines_cleared <= count;
        end
        default: ;
      endcase
    end
  end

endmodule
